// File: rtl/uart_tx_pkg.sv
// Shared types and TX output-mux select codes for the UART transmit frame sequencer.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_STOP   = 2'b01;
    localparam logic [1:0] SEL_DATA   = 2'b10;
    localparam logic [1:0] SEL_PARITY = 2'b11;

    // Idle and stop both drive the line high, so anything unknown maps there.
    function automatic logic [1:0] state_to_sel(input state_t s);
        case (s)
            ST_START:  return SEL_START;
            ST_DATA:   return SEL_DATA;
            ST_PARITY: return SEL_PARITY;
            default:   return SEL_STOP;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter; load clears the count, shift_en
// moves the next bit into the LSB, ser_done flags the final data bit.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  ser_bit,
    output logic                  ser_done
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            shreg_d = din;
            cnt_d   = '0;
        end else if (shift_en) begin
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ser_bit  = shreg_q[0];
    assign ser_done = (cnt_q == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, LSB-first data, optional parity, stop.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            Mux_Sel,
    output logic                  Ser_Data,
    output logic                  Par_Bit,
    output logic                  Busy
);

    state_t state_q, state_d;
    logic   accept;
    logic   shift_en;
    logic   ser_done;

    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .clk      (clk),
        .rst_n    (rst),
        .load     (accept),
        .shift_en (shift_en),
        .din      (P_DATA),
        .ser_bit  (Ser_Data),
        .ser_done (ser_done)
    );

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_bit_q, par_bit_d;

    always_comb begin
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        if (accept) begin
            par_en_d  = PAR_EN;
            par_bit_d = (^P_DATA) ^ PAR_TYP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end

    assign Par_Bit = par_bit_q;
`else
    logic unused_par_inputs;
    assign unused_par_inputs = PAR_EN ^ PAR_TYP;
    assign Par_Bit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Data_Valid) begin
                    accept  = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_DATA;
            ST_DATA: begin
                shift_en = 1'b1;
                if (ser_done) begin
`ifdef UART_TX_PARITY_EN
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
                    state_d = ST_STOP;
`endif
                end
            end
            ST_PARITY: state_d = ST_STOP;
            ST_STOP: begin
                // A payload offered during stop chains straight into the next frame.
                if (Data_Valid) begin
                    accept  = 1'b1;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    assign Mux_Sel = state_to_sel(state_q);
    assign Busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl; outputs are sampled on the falling edge.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [1:0] Mux_Sel;
    logic       Ser_Data;
    logic       Par_Bit;
    logic       Busy;

    int checks = 0;
    int errors = 0;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Mux_Sel    (Mux_Sel),
        .Ser_Data   (Ser_Data),
        .Par_Bit    (Par_Bit),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0; P_DATA = 8'h00; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        @(negedge clk);
        checks++;
        if (Mux_Sel !== 2'b01 || Busy !== 1'b0 || Ser_Data !== 1'b0 || Par_Bit !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: sel=%b busy=%b ser=%b par=%b want 01 0 0 0", Mux_Sel, Busy, Ser_Data, Par_Bit);
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (Mux_Sel !== 2'b01 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold[%0d]: sel=%b busy=%b want 01 0", i, Mux_Sel, Busy);
            end
        end
        $display("reset + idle: done");
    endtask

    task automatic test_frame_a5();
        logic [7:0] exp_data = 8'hA5;
        int busy_cycles = 0;
        P_DATA = exp_data; PAR_EN = 1'b0; Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        checks++;
        if (Mux_Sel !== 2'b00 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL a5_start: sel=%b busy=%b want 00 1", Mux_Sel, Busy);
        end
        busy_cycles += int'(Busy);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            busy_cycles += int'(Busy);
            checks++;
            if (Mux_Sel !== 2'b10 || Ser_Data !== exp_data[i]) begin
                errors++;
                $display("FAIL a5_data[%0d]: sel=%b ser=%b want 10 %b", i, Mux_Sel, Ser_Data, exp_data[i]);
            end
        end
        @(negedge clk);
        busy_cycles += int'(Busy);
        checks++;
        if (Mux_Sel !== 2'b01 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL a5_stop: sel=%b busy=%b want 01 1", Mux_Sel, Busy);
        end
        @(negedge clk);
        busy_cycles += int'(Busy);
        checks++;
        if (Mux_Sel !== 2'b01 || Busy !== 1'b0 || busy_cycles != 10) begin
            errors++;
            $display("FAIL a5_end: sel=%b busy=%b busy_cycles=%0d want 01 0 10", Mux_Sel, Busy, busy_cycles);
        end
        $display("frame A5 no parity: busy_cycles=%0d", busy_cycles);
    endtask

    task automatic test_parity(input logic typ);
        logic [7:0] exp_data = 8'h0F;
        logic       exp_par;
`ifdef UART_TX_PARITY_EN
        exp_par = typ;          // 0x0F has four ones, so even parity is 0
`else
        exp_par = 1'b0;
`endif
        P_DATA = exp_data; PAR_EN = 1'b1; PAR_TYP = typ; Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        PAR_EN = 1'b0; PAR_TYP = ~typ; P_DATA = 8'h01;
        checks++;
        if (Mux_Sel !== 2'b00 || Par_Bit !== exp_par) begin
            errors++;
            $display("FAIL par%0d_start: sel=%b par=%b want 00 %b", typ, Mux_Sel, Par_Bit, exp_par);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (Mux_Sel !== 2'b10 || Ser_Data !== exp_data[i] || Par_Bit !== exp_par) begin
                errors++;
                $display("FAIL par%0d_data[%0d]: sel=%b ser=%b par=%b want 10 %b %b",
                         typ, i, Mux_Sel, Ser_Data, Par_Bit, exp_data[i], exp_par);
            end
        end
`ifdef UART_TX_PARITY_EN
        @(negedge clk);
        checks++;
        if (Mux_Sel !== 2'b11 || Par_Bit !== exp_par || Busy !== 1'b1) begin
            errors++;
            $display("FAIL par%0d_parity: sel=%b par=%b busy=%b want 11 %b 1", typ, Mux_Sel, Par_Bit, Busy, exp_par);
        end
`endif
        @(negedge clk);
        checks++;
        if (Mux_Sel !== 2'b01 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL par%0d_stop: sel=%b busy=%b want 01 1", typ, Mux_Sel, Busy);
        end
        @(negedge clk);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL par%0d_end: busy=%b want 0", typ, Busy);
        end
        $display("frame 0F parity typ=%0d: par_bit expected %b", typ, exp_par);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d0 = 8'h55;
        logic [7:0] d1 = 8'hAA;
        P_DATA = d0; PAR_EN = 1'b0; Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (Mux_Sel !== 2'b10 || Ser_Data !== d0[i]) begin
                errors++;
                $display("FAIL b2b_f0_data[%0d]: sel=%b ser=%b want 10 %b", i, Mux_Sel, Ser_Data, d0[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (Mux_Sel !== 2'b01 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_f0_stop: sel=%b busy=%b want 01 1", Mux_Sel, Busy);
        end
        P_DATA = d1; Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        checks++;
        if (Mux_Sel !== 2'b00 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_f1_start: sel=%b busy=%b want 00 1", Mux_Sel, Busy);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (Mux_Sel !== 2'b10 || Ser_Data !== d1[i]) begin
                errors++;
                $display("FAIL b2b_f1_data[%0d]: sel=%b ser=%b want 10 %b", i, Mux_Sel, Ser_Data, d1[i]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (Busy !== 1'b0 || Mux_Sel !== 2'b01) begin
            errors++;
            $display("FAIL b2b_end: sel=%b busy=%b want 01 0", Mux_Sel, Busy);
        end
        $display("back-to-back 55 then AA: done");
    endtask

    task automatic test_ignore_busy();
        P_DATA = 8'h00; PAR_EN = 1'b0; Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (Mux_Sel !== 2'b10 || Ser_Data !== 1'b0) begin
                errors++;
                $display("FAIL ignore_data[%0d]: sel=%b ser=%b want 10 0", i, Mux_Sel, Ser_Data);
            end
            if (i == 3) begin
                P_DATA = 8'hFF; Data_Valid = 1'b1;
            end else begin
                Data_Valid = 1'b0;
            end
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (Busy !== 1'b0 || Mux_Sel !== 2'b01) begin
                errors++;
                $display("FAIL ignore_no_extra[%0d]: sel=%b busy=%b want 01 0", i, Mux_Sel, Busy);
            end
        end
        $display("mid-frame Data_Valid ignored: done");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d = 8'h0F;
        P_DATA = 8'hA5; PAR_EN = 1'b0; Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        checks++;
        if (Mux_Sel !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_pre: sel=%b want 10", Mux_Sel);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (Mux_Sel !== 2'b01 || Busy !== 1'b0 || Ser_Data !== 1'b0 || Par_Bit !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: sel=%b busy=%b ser=%b par=%b want 01 0 0 0", Mux_Sel, Busy, Ser_Data, Par_Bit);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle: busy=%b want 0", Busy);
        end
        P_DATA = d; Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        checks++;
        if (Mux_Sel !== 2'b00 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_restart: sel=%b busy=%b want 00 1", Mux_Sel, Busy);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (Mux_Sel !== 2'b10 || Ser_Data !== d[i]) begin
                errors++;
                $display("FAIL rstmid_data[%0d]: sel=%b ser=%b want 10 %b", i, Mux_Sel, Ser_Data, d[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (Mux_Sel !== 2'b01 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_stop: sel=%b busy=%b want 01 1", Mux_Sel, Busy);
        end
        @(negedge clk);
        $display("reset mid-frame then clean frame: done");
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_parity(1'b0);
        test_parity(1'b1);
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame sequencer for the UART transmitter: accepts a parallel byte with a valid strobe, latches it, and steps the TX output multiplexer through start, data (LSB first), optional parity and stop bits, one bit per clock (clock is the baud tick). It owns the data shift register, bit counter and parity generator. Its `Mux_Sel`, `Ser_Data` and `Par_Bit` outputs drive the 4:1 TX output mux directly.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame (≥ 1)
- `clk`  in  1  transmit bit clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `P_DATA`  in  DATA_WIDTH  parallel payload
- `Data_Valid`  in  1  payload-present strobe, sampled only when a frame may be accepted
- `PAR_EN`  in  1  parity bit inserted when 1
- `PAR_TYP`  in  1  0 = even, 1 = odd parity
- `Mux_Sel`  out  2  00 start, 01 stop/idle, 10 data, 11 parity
- `Ser_Data`  out  1  current data bit (shift register LSB)
- `Par_Bit`  out  1  parity of latched payload
- `Busy`  out  1  frame in progress

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `Mux_Sel`=01 (line high), `Busy`=0. `Data_Valid`=1 → latch `P_DATA`, `PAR_EN`, `PAR_TYP`; compute parity; go to START.
- START: `Mux_Sel`=00, one cycle → DATA; clear bit counter.
- DATA: `Mux_Sel`=10, `Ser_Data`=shift-register LSB; shift right each cycle; counter increments; after DATA_WIDTH cycles → PARITY if latched PAR_EN, else STOP.
- PARITY: `Mux_Sel`=11, one cycle → STOP.
- STOP: `Mux_Sel`=01, one cycle. `Data_Valid`=1 here → latch new payload, go to START (back-to-back, no idle gap); else → IDLE.
- `Par_Bit` = XOR-reduce(latched data) XOR latched PAR_TYP; held stable for the whole frame.
- `P_DATA`, `PAR_EN`, `PAR_TYP` changes while `Busy` have no effect on the current frame.
- `Data_Valid` in START/DATA/PARITY is ignored (not queued).
- Counter width = clog2(DATA_WIDTH+1); no wrap: exits DATA on count DATA_WIDTH-1.

## Timing
- Reset (async assert, sync deassert externally): state IDLE, `Mux_Sel`=01, `Ser_Data`=0, `Par_Bit`=0, `Busy`=0, shift register and counter 0.
- Reset mid-frame: output returns to 01 immediately; frame discarded.
- Latency: `Data_Valid` high at edge N → START visible after edge N (cycle N+1); `Busy` rises same edge.
- Frame length: 2 + DATA_WIDTH + PAR_EN cycles; `Busy` high for START through STOP inclusive.
- Back-to-back: STOP at cycle k with `Data_Valid` → START at k+1; `Busy` stays high.
- All outputs registered or decoded from registered state only; no input-to-output combinational path.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state and parity generator present as above.
- Undefined: PARITY state and parity logic removed; `PAR_EN`/`PAR_TYP` ignored; `Mux_Sel` never 11; `Par_Bit` tied 0; frame always 2 + DATA_WIDTH cycles.

## Structure
- Package `uart_tx_pkg`: state enum encoding; `Mux_Sel` constants (SEL_START=00, SEL_STOP=01, SEL_DATA=10, SEL_PARITY=11).
- Sub-module `uart_tx_serializer`: load/shift register plus bit counter, with `load`, `shift_en`, `ser_done` handshake to the FSM. FSM and parity stay in `uart_tx_ctrl`.

## Test plan
- Reset, then hold idle 5 cycles → `Mux_Sel`=01, `Busy`=0 throughout.
- `P_DATA`=8'hA5, PAR_EN=0 → Mux_Sel sequence 00, 10×8, 01; Ser_Data 1,0,1,0,0,1,0,1; Busy high 10 cycles.
- `P_DATA`=8'h0F, PAR_EN=1, PAR_TYP=0 → PARITY cycle `Mux_Sel`=11, `Par_Bit`=0; PAR_TYP=1 repeat → `Par_Bit`=1; 11-cycle frame.
- 8'h55 then 8'hAA with `Data_Valid` asserted in STOP → second START immediately after STOP; Busy never drops.
- Change `P_DATA` to 8'hFF and pulse `Data_Valid` mid-DATA of frame 8'h00 → all data bits 0, no extra frame.
- Assert `rst` low in DATA bit 3 → `Mux_Sel`=01, `Busy`=0 asynchronously; next `Data_Valid` starts a clean frame.
